// File: rtl/skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : skid_buffer
// Description : Two-entry ready/valid skid buffer. Words are held in a main
//               register (drives out_data) and a skid register that catches
//               a word arriving while the main word is stalled. All handshake
//               outputs decode from the state register alone, so neither
//               in_ready nor out_valid has a combinational path from the
//               opposite side of the interface.
// Ports       : CLK        - rising-edge clock for all state
//               Reset      - asynchronous, active-high reset
//               flush      - synchronous discard of all held words
//               in_valid   - upstream word present
//               in_data    - upstream word
//               in_ready   - buffer accepts a word this cycle
//               out_valid  - out_data holds a valid word
//               out_data   - oldest held word
//               out_ready  - downstream consumes the word this cycle
//               count      - number of held words, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       count
);

    // Encoding matches the occupancy so the state doubles as the count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    logic w_in_fire;
    logic w_out_fire;

    // Output decode from the state register only.
    always_comb begin
        in_ready  = (state_q != ST_FULL);
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_q;
        case (state_q)
            ST_EMPTY: count = 2'd0;
            ST_BUSY:  count = 2'd1;
            ST_FULL:  count = 2'd2;
            default:  count = 2'd0;
        endcase
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any handshake; register contents are left as-is
            // because out_valid=0 already hides them.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        main_d  = in_data;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_in_fire && w_out_fire) begin
                        // Pass-through: the new word replaces the departing one.
                        main_d = in_data;
                    end else if (w_in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (w_out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (w_out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skid_buffer
// Description : Self-checking bench for skid_buffer. The reference model is a
//               plain word queue holding at most two entries: the driver
//               pushes accepted words, the monitor compares the head against
//               out_data and pops it when the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skid_buffer;

    localparam int WIDTH = 32;

    logic             CLK;
    logic             Reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [1:0]       count;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];

    skid_buffer #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge; the model decides
    // acceptance from the occupancy it held before this cycle's edge.
    task automatic cycle(input logic v, input logic [31:0] d, input logic r, input logic f);
        bit m_ready;
        @(negedge CLK);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        m_ready   = (exp_q.size() < 2);
        #2;
        if (f)
            exp_q.delete();
        else if (v && m_ready)
            exp_q.push_back(d);
    endtask

    // Monitor: compares DUT status and head word against the model each
    // cycle, and retires the head word when the consumer takes it.
    always begin
        int n;
        @(negedge CLK);
        #1;
        n = exp_q.size();
        check("count", 32'(count), 32'(n));
        check("out_valid", 32'(out_valid), 32'(n > 0));
        check("in_ready", 32'(in_ready), 32'(n < 2));
        if (n > 0) begin
            check("out_data", out_data, exp_q[0]);
            if (out_ready && !flush)
                void'(exp_q.pop_front());
        end
    end

    initial begin
        Reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Outputs held at their reset values while Reset is high.
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        #6;
        check("rst_out_valid_edge", 32'(out_valid), 32'd0);
        check("rst_count_edge", 32'(count), 32'd0);
        #3;
        Reset = 1'b0;

        // Streaming at one word per cycle.
        cycle(1'b1, 32'h11101110, 1'b1, 1'b0);
        cycle(1'b1, 32'h024FBFF0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Backpressure: two words fill the buffer, a third is refused.
        cycle(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
        cycle(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
        cycle(1'b1, 32'hAAAA0003, 1'b0, 1'b0);
        cycle(1'b1, 32'hAAAA0003, 1'b0, 1'b0);
        // Drain with the third word still offered.
        cycle(1'b1, 32'hAAAA0003, 1'b1, 1'b0);
        cycle(1'b1, 32'hAAAA0003, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush while full, with a word offered that must vanish.
        cycle(1'b1, 32'hBBBB0001, 1'b0, 1'b0);
        cycle(1'b1, 32'hBBBB0002, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
        cycle(1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b1, 32'hCCCC0001, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges while full.
        cycle(1'b1, 32'hDDDD0001, 1'b0, 1'b0);
        cycle(1'b1, 32'hDDDD0002, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        // Now inside a low phase, well before the next rising edge.
        Reset = 1'b1;
        #1;
        check("async_count", 32'(count), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_out_data", out_data, 32'h0);
        check("async_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        @(negedge CLK);
        #3;
        Reset = 1'b0;
        cycle(1'b1, 32'hEEEE0001, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  32'($urandom()),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 31) == 0));
        end

        // Drain whatever is left.
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        @(negedge CLK);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
